// File: rtl/ram_loader_if.sv
// FIFO read side and RAM write port seen by ram_loader.
// The master side (ram_loader) pops the FIFO and drives the RAM write port.
// The slave side is the surrounding FIFO/RAM pair.
interface ram_loader_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
);
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_dout;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;

   modport master (
      input  fifo_empty, fifo_dout,
      output fifo_rd_en, ram_en, ram_we, ram_address, ram_data
   );

   modport slave (
      output fifo_empty, fifo_dout,
      input  fifo_rd_en, ram_en, ram_we, ram_address, ram_data
   );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: pops words from the upstream FIFO and writes them into
// consecutive RAM locations from a programmable base address for a
// programmable word count. Each word takes one FETCH cycle (pop) and one
// WRITE cycle (FIFO data is valid the cycle after the pop). Completion is
// signalled with a one-cycle done pulse. An abort ends the transfer early
// and produces no done pulse.
module ram_loader #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              abort,
   ram_loader_if.master      bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words_written
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WRITE,
      S_DONE
   } state_t;

   // A transfer can never exceed the RAM size.
   localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   remaining_q;
   logic [ADDR_W:0]   length_clamped;

   assign length_clamped  = (length > MAX_LEN) ? MAX_LEN : length;
   assign busy            = (state_q != S_IDLE);
   assign bus.ram_address = addr_q;

   // State register; reset forces IDLE, which also zeroes every strobe.
   // NOTE: clocked state uses non-blocking (<=) so all registers update
   // together from pre-edge values; blocking here would create order races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Address, remaining count and written count for the active transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q        <= '0;
         remaining_q   <= '0;
         words_written <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  words_written <= '0;
                  if (length != '0) begin
                     addr_q      <= base_addr;
                     remaining_q <= length_clamped;
                  end
               end
            end
            S_WRITE: begin
               addr_q        <= addr_q + ADDR_ONE;       // wraps modulo 2^ADDR_W
               remaining_q   <= remaining_q - CNT_ONE;
               words_written <= words_written + CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   // Next-state decode and the FIFO/RAM strobes for the current state.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned; an unassigned path would infer a latch.
   always_comb begin
      state_d        = state_q;
      bus.fifo_rd_en = 1'b0;
      bus.ram_en     = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_data   = '0;
      done           = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (length == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            // A pop issued alongside an abort still happens; the word is lost.
            bus.fifo_rd_en = !bus.fifo_empty;
            if (abort)                state_d = S_IDLE;
            else if (!bus.fifo_empty) state_d = S_WRITE;
         end
         S_WRITE: begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = 1'b1;
            bus.ram_data = bus.fifo_dout;
            if (abort)                   state_d = S_IDLE;
            else if (remaining_q == CNT_ONE) state_d = S_DONE;
            else                         state_d = S_FETCH;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_loader.sv
// Directed testbench for ram_loader: a small FIFO model feeds the block,
// a negedge monitor logs RAM writes and done pulses, and each scenario
// compares against hand-computed addresses, data and cycle numbers.
module tb_ram_loader;
   localparam int DATA_W = 4;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   words_written;

   ram_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .length        (length),
      .abort         (abort),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .words_written (words_written)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Global cycle counter; relative cycle = cyc - t0.
   int cyc = 0;
   int t0  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: registered read, data valid the cycle after a pop.
   logic [DATA_W-1:0] fifo_mem [64];
   logic [DATA_W-1:0] dout_q = '0;
   int                rd_ptr = 0;
   int                wr_ptr = 0;
   logic              flush = 1'b0;
   assign bus.fifo_empty = (rd_ptr == wr_ptr);
   assign bus.fifo_dout  = dout_q;

   // Pop on rd_en; flush discards leftover words between scenarios.
   always @(posedge clk) begin
      if (flush) rd_ptr <= wr_ptr;
      else if (bus.fifo_rd_en && !bus.fifo_empty) begin
         dout_q <= fifo_mem[rd_ptr % 64];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // Monitor: log writes, done pulses and illegal pops away from the clock edge.
   logic [ADDR_W-1:0] w_addr [256];
   logic [DATA_W-1:0] w_data [256];
   int                w_rel  [256];
   int nw = 0, nd = 0, done_rel = 0, rd_viol = 0;
   always @(negedge clk) begin
      if (bus.ram_en && bus.ram_we) begin
         if (nw < 256) begin
            w_addr[nw] = bus.ram_address;
            w_data[nw] = bus.ram_data;
            w_rel[nw]  = cyc - t0;
         end
         nw = nw + 1;
      end
      if (done) begin
         nd       = nd + 1;
         done_rel = cyc - t0;
      end
      if (bus.fifo_rd_en && bus.fifo_empty) rd_viol = rd_viol + 1;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      fifo_mem[wr_ptr % 64] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
   endtask

   // Accept a start on the next edge; returns positioned in relative cycle 1.
   task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
      base_addr = b;
      length    = l;
      start     = 1'b1;
      t0        = cyc;
      tick(1);
      start     = 1'b0;
   endtask

   // Wait for one done pulse; returns in the first cycle after it.
   task automatic wait_done(input string tag, input int nd0, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (nd > nd0) break;
      end
      check({tag, "_done_seen"}, 32'(nd - nd0), 32'd1);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic check_write(input string tag, input int idx, input int exp_addr,
                              input int exp_data, input int exp_rel);
      check($sformatf("%s_addr%0d", tag, idx), 32'(w_addr[idx]), 32'(exp_addr));
      check($sformatf("%s_data%0d", tag, idx), 32'(w_data[idx]), 32'(exp_data));
      if (exp_rel >= 0) check($sformatf("%s_cyc%0d", tag, idx), 32'(w_rel[idx]), 32'(exp_rel));
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({busy, done, bus.ram_en, bus.ram_we, bus.fifo_rd_en,
                  bus.ram_address, bus.ram_data, words_written});
   endfunction

   // Safety net in case the bench ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
      $fatal(1, "watchdog");
   end

   // Directed scenarios.
   initial begin
      int w0, d0;

      // Reset values
      tick(2);
      check("reset_outs", all_outs(), 32'd0);
      rst = 1'b1;
      tick(2);
      check("idle_busy", 32'(busy), 32'd0);

      // Basic transfer: base 3, length 3, data 1,2,3
      w0 = nw; d0 = nd;
      push(4'h1); push(4'h2); push(4'h3);
      start_xfer(4'd3, 5'd3);
      check("basic_busy_c1", 32'(busy), 32'd1);
      check("basic_rd_c1", 32'(bus.fifo_rd_en), 32'd1);
      wait_done("basic", d0, 40);
      check("basic_nw", 32'(nw - w0), 32'd3);
      for (int i = 0; i < 3; i++) check_write("basic", w0 + i, 3 + i, 1 + i, 2 * (i + 1));
      check("basic_done_cyc", 32'(done_rel), 32'd7);
      check("basic_words", 32'(words_written), 32'd3);
      tick(3);
      check("basic_words_hold", 32'(words_written), 32'd3);
      check("basic_single_done", 32'(nd - d0), 32'd1);

      // Address wrap: base 14, length 4, data A..D
      w0 = nw; d0 = nd;
      push(4'hA); push(4'hB); push(4'hC); push(4'hD);
      start_xfer(4'd14, 5'd4);
      wait_done("wrap", d0, 40);
      check("wrap_nw", 32'(nw - w0), 32'd4);
      check_write("wrap", w0 + 0, 14, 'hA, 2);
      check_write("wrap", w0 + 1, 15, 'hB, 4);
      check_write("wrap", w0 + 2, 0,  'hC, 6);
      check_write("wrap", w0 + 3, 1,  'hD, 8);
      check("wrap_done_cyc", 32'(done_rel), 32'd9);
      tick(2);
      check("wrap_single_done", 32'(nd - d0), 32'd1);

      // FIFO starvation: empty cycles 1-5, word, empty 3 cycles, word
      w0 = nw; d0 = nd;
      start_xfer(4'd6, 5'd2);
      check("starve_rd_c1", 32'(bus.fifo_rd_en), 32'd0);
      check("starve_busy_c1", 32'(busy), 32'd1);
      tick(5);
      push(4'h5);
      tick(5);
      push(4'h9);
      wait_done("starve", d0, 40);
      check("starve_nw", 32'(nw - w0), 32'd2);
      check_write("starve", w0 + 0, 6, 'h5, 7);
      check_write("starve", w0 + 1, 7, 'h9, 12);
      check("starve_done_cyc", 32'(done_rel), 32'd13);
      check("starve_rd_viol", 32'(rd_viol), 32'd0);
      check("starve_words", 32'(words_written), 32'd2);

      // Zero length: done in cycle 1, no RAM activity
      w0 = nw; d0 = nd;
      start_xfer(4'd5, 5'd0);
      check("zero_done_c1", 32'(done), 32'd1);
      check("zero_busy_c1", 32'(busy), 32'd1);
      check("zero_en_c1", 32'(bus.ram_en), 32'd0);
      wait_done("zero", d0, 10);
      check("zero_done_cyc", 32'(done_rel), 32'd1);
      check("zero_nw", 32'(nw - w0), 32'd0);
      check("zero_words", 32'(words_written), 32'd0);

      // Length 31 clamps to 16 writes
      w0 = nw; d0 = nd;
      for (int i = 0; i < 16; i++) push(4'(i ^ 5));
      start_xfer(4'd0, 5'd31);
      wait_done("clamp", d0, 100);
      check("clamp_nw", 32'(nw - w0), 32'd16);
      for (int i = 0; i < 16; i++) check_write("clamp", w0 + i, i, (i ^ 5) & 'hF, 2 * (i + 1));
      check("clamp_done_cyc", 32'(done_rel), 32'd33);
      check("clamp_words", 32'(words_written), 32'd16);

      // Abort in the WRITE cycle of word 2 of 5
      w0 = nw; d0 = nd;
      for (int i = 1; i <= 5; i++) push(4'(i));
      start_xfer(4'd2, 5'd5);
      tick(3);
      check("abort_en_c4", 32'(bus.ram_en), 32'd1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_busy_after", 32'(busy), 32'd0);
      tick(3);
      check("abort_nw", 32'(nw - w0), 32'd2);
      check_write("abort", w0 + 0, 2, 1, 2);
      check_write("abort", w0 + 1, 3, 2, 4);
      check("abort_no_done", 32'(nd - d0), 32'd0);
      check("abort_words", 32'(words_written), 32'd2);
      do_flush();

      // Start pulsed while busy is ignored
      w0 = nw; d0 = nd;
      push(4'h7); push(4'h8); push(4'h9);
      start_xfer(4'd8, 5'd3);
      base_addr = 4'd0;
      length    = 5'd1;
      start     = 1'b1;
      tick(2);
      start = 1'b0;
      wait_done("busy_start", d0, 40);
      check("busy_start_nw", 32'(nw - w0), 32'd3);
      for (int i = 0; i < 3; i++) check_write("busy_start", w0 + i, 8 + i, 7 + i, 2 * (i + 1));
      check("busy_start_done_cyc", 32'(done_rel), 32'd7);
      tick(3);
      check("busy_start_single", 32'(nd - d0), 32'd1);
      check("busy_start_words", 32'(words_written), 32'd3);

      // Reset asserted mid-WRITE, then a normal 2-word transfer
      push(4'h6); push(4'h7); push(4'h8);
      start_xfer(4'd4, 5'd3);
      tick(1);
      check("rst_mid_en", 32'(bus.ram_en), 32'd1);
      w0 = nw;
      rst = 1'b0;
      #1;
      check("rst_mid_outs", all_outs(), 32'd0);
      tick(2);
      check("rst_hold_outs", all_outs(), 32'd0);
      check("rst_no_write", 32'(nw - w0), 32'd0);
      rst = 1'b1;
      do_flush();
      w0 = nw; d0 = nd;
      push(4'hC); push(4'hD);
      start_xfer(4'd9, 5'd2);
      wait_done("post_rst", d0, 40);
      check("post_rst_nw", 32'(nw - w0), 32'd2);
      check_write("post_rst", w0 + 0, 9,  'hC, 2);
      check_write("post_rst", w0 + 1, 10, 'hD, 4);
      check("post_rst_done_cyc", 32'(done_rel), 32'd5);
      check("post_rst_words", 32'(words_written), 32'd2);
      check("final_rd_viol", 32'(rd_viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
